if_prefetch_queue: RTL

- Instruction-fetch front end for the 16-bit pipelined CPU; replaces the single-cycle fetch path that feeds the IF/ID pipeline register.
- Issues in-order word fetches to instruction memory over a valid/ready request channel with fixed-order responses.
- Buffers returned instructions with their PCs in a small queue. Presents the head entry to IF/ID.
- Supports stall from hazard logic and redirect on taken branch, discarding stale in-flight fetches.

---
 rtl/if_prefetch_queue_pkg.sv | 18 +
 rtl/if_fifo.sv | 69 ++++++
 rtl/if_prefetch_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared CPU front-end definitions: datapath widths, the NOP encoding and the
// {pc, instr} entry carried through the fetch queue.
package if_prefetch_queue_pkg;

  localparam int unsigned PcW    = 16;
  localparam int unsigned InstrW = 16;

  typedef logic [PcW-1:0]    pc_t;
  typedef logic [InstrW-1:0] instr_t;

  localparam instr_t NopInstr = 16'h0000;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries. Flush has priority over
// push/pop; the head entry is read straight from storage.
module if_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        count_d = count_q + CntW'(1);
      end else if (pop_i && !push_i) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; only count qualifies it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && !flush_i) |-> (count_q < CntW'(Depth) || pop_i));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches, queues the
// returned words with their PCs and presents the head entry to IF/ID.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter pc_t         ResetPc = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PcW-1:0]    imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [InstrW-1:0] imem_rsp_data_i,
  input  logic              stall_if_i,
  input  logic              branch_taken_i,
  input  logic [PcW-1:0]    branch_target_i,
  output logic              if_valid_o,
  output logic [PcW-1:0]    if_pc_o,
  output logic [InstrW-1:0] if_instr_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam int unsigned OccW = CntW + 1;

  pc_t             fetch_pc_q, fetch_pc_d;
  pc_t             rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count;
  logic [OccW-1:0] occupancy;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            req_fire;
  logic            rsp_keep;
  logic            push;
  logic            pop;

  // Stale responses still count toward occupancy so a push can never overflow.
  assign occupancy = OccW'(count) + OccW'(inflight_q);

  assign imem_req_valid_o = rst_ni && !branch_taken_i && (occupancy < OccW'(Depth));
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_keep   = imem_rsp_valid_i && (drop_q == '0);
  assign push       = rsp_keep && !branch_taken_i;
  assign pop        = if_valid_o && !stall_if_i && !branch_taken_i;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    if (req_fire)         inflight_d = inflight_d + CntW'(1);
    if (imem_rsp_valid_i) inflight_d = inflight_d - CntW'(1);

    if (branch_taken_i) begin
      fetch_pc_d = branch_target_i;
      rsp_pc_d   = branch_target_i;
      // Everything still outstanding belongs to the old path.
      drop_d     = inflight_q - CntW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PcW'(1);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PcW'(1);
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= ResetPc;
      rsp_pc_q   <= ResetPc;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  if_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (branch_taken_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign if_valid_o = (count != '0);
  assign if_pc_o    = if_valid_o ? head.pc : '0;
  assign if_instr_o = if_valid_o ? head.instr : NopInstr;

endmodule
